hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/freeze sequencing, operand forwarding,
// freeze watchdog. Define HAZARD_PERF_CNT_EN to build the StallCnt perf counter.
module hazard_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_UseRs,
  input  logic        ID_UseRt,
  input  logic [4:0]  EX_rs,
  input  logic [4:0]  EX_rt,
  input  logic        EX_MemRd,
  input  logic        EX_RegWr,
  input  logic [4:0]  EX_WrReg,
  input  logic        MEM_RegWr,
  input  logic [4:0]  MEM_WrReg,
  input  logic        WB_RegWr,
  input  logic [4:0]  WB_WrReg,
  input  logic        EX_BrTaken,
  input  logic        ID_Jump,
  input  logic        Mem_busy,
  input  logic        Irq,
  output logic        PC_Wr,
  output logic        IFID_Wr,
  output logic        IFID_Flush,
  output logic        IDEX_Stall,
  output logic        Pipe_Freeze,
  output logic        PC_SelExc,
  output logic [1:0]  FwdA,
  output logic [1:0]  FwdB,
  output logic        Timeout_Err,
  output logic [31:0] StallCnt
);

  typedef enum logic {RUN, FREEZE} state_t;

  state_t     state_q, state_d;
  logic       irq_pend_q, irq_pend_d;
  logic [7:0] frz_cnt_q, frz_cnt_d;
  logic       tmo_err_q, tmo_err_d;
  logic       irq_svc, load_use;

  // Load detection only needs the load flag; the write enable is implied.
  logic unused_ex_regwr;
  assign unused_ex_regwr = EX_RegWr;

  assign irq_svc  = !Mem_busy && (Irq || irq_pend_q);
  assign load_use = EX_MemRd && (EX_WrReg != 5'd0) &&
                    ((ID_UseRs && (EX_WrReg == ID_rs)) ||
                     (ID_UseRt && (EX_WrReg == ID_rt)));

  always_comb begin
    state_d    = state_q;
    irq_pend_d = irq_pend_q;
    case (state_q)
      RUN:     if (Mem_busy)  state_d = FREEZE;
      FREEZE:  if (!Mem_busy) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (Mem_busy && Irq) irq_pend_d = 1'b1;
    else if (irq_svc)    irq_pend_d = 1'b0;
  end

  always_comb begin
    PC_Wr       = 1'b1;
    IFID_Wr     = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Stall  = 1'b0;
    Pipe_Freeze = 1'b0;
    PC_SelExc   = 1'b0;
    if (reset) begin
      PC_Wr      = 1'b0;
      IFID_Wr    = 1'b0;
      IFID_Flush = 1'b1;
      IDEX_Stall = 1'b1;
    end else if (Mem_busy) begin
      PC_Wr       = 1'b0;
      IFID_Wr     = 1'b0;
      Pipe_Freeze = 1'b1;
    end else if (irq_svc) begin
      PC_SelExc  = 1'b1;
      IFID_Flush = 1'b1;
      IDEX_Stall = 1'b1;
    end else if (EX_BrTaken) begin
      IFID_Flush = 1'b1;
      IDEX_Stall = 1'b1;
    end else if (ID_Jump) begin
      IFID_Flush = 1'b1;
    end else if (load_use) begin
      PC_Wr      = 1'b0;
      IFID_Wr    = 1'b0;
      IDEX_Stall = 1'b1;
    end
  end

  // MEM result is newer than WB, so it takes precedence.
  always_comb begin
    FwdA = 2'b00;
    FwdB = 2'b00;
    if (!reset) begin
      if (MEM_RegWr && MEM_WrReg != 5'd0 && MEM_WrReg == EX_rs)   FwdA = 2'b10;
      else if (WB_RegWr && WB_WrReg != 5'd0 && WB_WrReg == EX_rs) FwdA = 2'b01;
      if (MEM_RegWr && MEM_WrReg != 5'd0 && MEM_WrReg == EX_rt)   FwdB = 2'b10;
      else if (WB_RegWr && WB_WrReg != 5'd0 && WB_WrReg == EX_rt) FwdB = 2'b01;
    end
  end

  always_comb begin
    frz_cnt_d = 8'd0;
    if (Mem_busy) frz_cnt_d = (frz_cnt_q == 8'hFF) ? frz_cnt_q : frz_cnt_q + 8'd1;
    tmo_err_d = tmo_err_q || (frz_cnt_d >= 8'(TIMEOUT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      irq_pend_q <= 1'b0;
      frz_cnt_q  <= 8'd0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_pend_q <= irq_pend_d;
      frz_cnt_q  <= frz_cnt_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign Timeout_Err = tmo_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PC_Wr && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= 32'd0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign StallCnt = stall_cnt_q;
`else
  assign StallCnt = 32'd0;
`endif

endmodule
